// File: rtl/fft_input_stage_if.sv
// Sample-in / RAM-write bundle for fft_input_stage.
// Handshake: a pair transfers on a rising clk edge where in_valid && in_ready; no other edge moves data.
interface fft_input_stage_if #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WORD_SIZE-1:0] sample1;
  logic [2*WORD_SIZE-1:0] sample2;
  logic [2*WORD_SIZE-1:0] comp1;
  logic [2*WORD_SIZE-1:0] comp2;
  logic [ADDR_WIDTH-1:0]  addr1;
  logic [ADDR_WIDTH-1:0]  addr2;
  logic                   wr_en;

  modport master (
    output in_valid, sample1, sample2,
    input  in_ready, comp1, comp2, addr1, addr2, wr_en
  );

  modport slave (
    input  in_valid, sample1, sample2,
    output in_ready, comp1, comp2, addr1, addr2, wr_en
  );
endinterface

// File: rtl/fft_input_stage.sv
// Radix-2 stage-0 butterfly with frame sequencing and paired RAM write addresses.
// Define FFT_INPUT_BITREV_EN to emit bit-reversed write addresses instead of natural order.
module fft_input_stage #(
  parameter int N          = 32,
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int SCALE      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  fft_input_stage_if.slave bus,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow,
  output logic [1:0]       fsm_state
);
  localparam int W  = WORD_SIZE;
  localparam int EW = WORD_SIZE + 1;
  localparam int KW = ADDR_WIDTH - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);

  logic [1:0]            state;
  logic [KW-1:0]         k;
  logic [ADDR_WIDTH-1:0] nat_addr;
  logic [2*W-1:0]        comp1_q;
  logic [2*W-1:0]        comp2_q;
  logic                  wr_en_q;
  logic                  accept;
  logic                  last_pair;
  logic                  pair_ovf;

  logic signed [EW-1:0] re1, im1, re2, im2;
  logic signed [EW-1:0] sum_re, sum_im, dif_re, dif_im;

  function automatic logic [W-1:0] fit(input logic signed [EW-1:0] v);
    if (SCALE != 0) fit = v[EW-1:1];
    else            fit = v[W-1:0];
  endfunction

  function automatic logic wraps(input logic signed [EW-1:0] v);
    return v[EW-1] ^ v[EW-2];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef FFT_INPUT_BITREV_EN
    for (int i = 0; i < ADDR_WIDTH; i++) map_addr[i] = a[ADDR_WIDTH-1-i];
`else
    map_addr = a;
`endif
  endfunction

  assign bus.in_ready = (state == ST_RUN) && en;
  assign accept       = bus.in_ready && bus.in_valid;
  assign last_pair    = (k == K_LAST);

  assign re1 = {bus.sample1[2*W-1], bus.sample1[2*W-1:W]};
  assign im1 = {bus.sample1[W-1],   bus.sample1[W-1:0]};
  assign re2 = {bus.sample2[2*W-1], bus.sample2[2*W-1:W]};
  assign im2 = {bus.sample2[W-1],   bus.sample2[W-1:0]};

  // One extra bit of headroom makes every sum/difference exact.
  assign sum_re = re1 + re2;
  assign sum_im = im1 + im2;
  assign dif_re = re1 - re2;
  assign dif_im = im1 - im2;

  assign pair_ovf = (SCALE == 0) &&
                    (wraps(sum_re) || wraps(sum_im) || wraps(dif_re) || wraps(dif_im));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      k          <= '0;
      nat_addr   <= '0;
      comp1_q    <= '0;
      comp2_q    <= '0;
      wr_en_q    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // accept already requires en, so both strobes drop whenever en is low.
      wr_en_q    <= accept;
      frame_done <= accept && last_pair;
      if (en) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_RUN;
              k        <= '0;
              overflow <= 1'b0;
            end
          end
          ST_RUN: begin
            if (accept) begin
              comp1_q  <= {fit(sum_re), fit(sum_im)};
              comp2_q  <= {fit(dif_re), fit(dif_im)};
              nat_addr <= {k, 1'b0};
              k        <= k + 1'b1;
              if (pair_ovf) overflow <= 1'b1;
              if (last_pair) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (start) begin
              state    <= ST_RUN;
              k        <= '0;
              overflow <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.comp1 = comp1_q;
  assign bus.comp2 = comp2_q;
  assign bus.wr_en = wr_en_q;
  assign bus.addr1 = map_addr(nat_addr);
  assign bus.addr2 = map_addr(nat_addr | ADDR_WIDTH'(1));
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;
endmodule
